instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Consumer end of the program-counter interface.
- Accepts word-indexed instruction addresses (PC increments by 1 per instruction; no byte offset) from the program counter.
- Reads a synchronous instruction memory with 1-cycle latency and buffers returned instructions with their PC in a small queue.
- Presents instructions to decode over a valid/ready handshake; a branch-taken flush discards all fetched-but-undelivered work.

Parameters:
- N, 32, address/PC width in bits.
- W, 32, instruction width in bits.
- DEPTH, 2, fetch queue entries; power of 2, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- pc_in  input  N  instruction address from the program counter.
- pc_valid  input  1  pc_in is valid this cycle.
- pc_ready  output  1  fetch accepts pc_in this cycle.
- imem_en  output  1  instruction memory read enable.
- imem_addr  output  N  instruction memory read address.
- imem_rdata  input  W  memory data, valid the cycle after imem_en.
- flush  input  1  branch redirect; discard queued and in-flight instructions.
- inst_out  output  W  instruction at queue head.
- inst_pc  output  N  PC of inst_out.
- inst_valid  output  1  queue head is valid.
- inst_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (async, rst=1):
  - count=0, rd_ptr=wr_ptr=0, inflight=0, inflight_pc=0.
  - inst_valid=0, inst_out=0, inst_pc=0.
  - pc_ready=0 while rst is asserted.
  - Reset mid-operation drops all queued and in-flight data with no output glitch after deassertion.
- Credit rule: pc_ready = !rst && !flush && (count + inflight < DEPTH). count is clog2(DEPTH)+1 bits wide.
- Accept: when pc_valid && pc_ready:
  - imem_en=1 and imem_addr=pc_in (combinational, same cycle).
  - At posedge: inflight<=1 and inflight_pc<=pc_in.
- Outside accept cycles: imem_en=0 and imem_addr holds its last value.
- Return: in the cycle after an accept, if inflight && !flush:
  - {imem_rdata, inflight_pc} is written at wr_ptr; wr_ptr and count increment.
  - inflight clears unless a new accept occurs in the same cycle.
- Throughput: back-to-back accepts give 1 instruction/cycle at steady state when decode drains every cycle.
- Output:
  - inst_valid = (count != 0).
  - inst_out and inst_pc come from the entry at rd_ptr.
  - A pop occurs when inst_valid && inst_ready: rd_ptr increments, count decrements.
- Fetch-to-decode latency: 2 cycles (accept at cycle t, data written at t+1 posedge, inst_valid high in cycle t+1 after the edge).
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at count==DEPTH-1 with inflight set.
- Full: count+inflight==DEPTH forces pc_ready=0. No overflow is possible by construction.
- Empty: inst_valid=0. inst_ready is ignored.
- Pointer wrap: rd_ptr/wr_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
- Flush (1 cycle, synchronous):
  - At posedge: count<=0, pointers<=0, inflight<=0.
  - Returning imem_rdata that cycle is discarded.
  - The pop handshake is ignored that cycle; inst_valid falls next cycle.
  - pc_ready=0 during flush; the redirected PC is accepted from the following cycle.
- Flush has priority over accept, return, and pop when they coincide.
- pc_valid is ignored while pc_ready=0. The program counter must hold pc_in until accepted.

Optional Feature:
- Macro: FETCH_STATS_EN.
- With it defined:
  - Adds output fetch_count [31:0], incremented on each decode handshake (inst_valid && inst_ready, not in a flush cycle).
  - Adds output flush_count [31:0], incremented on each flush cycle.
  - Both counters reset to 0 and wrap at 2^32.
- Without it: neither port exists and no counter logic is synthesized.

Decomposition:
- Shared package rv_fetch_pkg:
  - localparams for default N/W/DEPTH.
  - Typedef fetch_entry_t {inst[W-1:0], pc[N-1:0]}.
  - NOP instruction constant, used as inst_out reset/empty value.
- Sub-module fetch_queue:
  - Synchronous FIFO of fetch_entry_t, DEPTH entries.
  - Ports: push, pop, clear, count.
  - instruction_fetch keeps the credit/inflight logic and memory interface.

Test Plan:
- Reset then pc_valid=1 with pc_in=0,1,2,3 on consecutive cycles, inst_ready=1, memory returning 32'hA000_0000+addr -> imem_en high each cycle; inst_valid from cycle 2; inst_pc=0,1,2,3 with matching inst_out; no bubbles.
- inst_ready=0 while issuing pc 0..3 -> pc_ready drops after 2 accepts (count=2); inst_valid stays 1 with inst_pc=0. Raising inst_ready drains 0,1, then resumes accepting pc=2.
- Flush in the cycle data for pc=5 returns, with pc=4 queued -> both discarded; inst_valid=0 next cycle; pc_in=20 is accepted the cycle after flush; inst_pc=20 is delivered 2 cycles later.
- Flush coincident with pc_valid and inst_ready -> pc_ready=0, no pop counted, no imem_en.
- Async rst asserted mid-stream between clock edges -> inst_valid=0 and pc_ready=0 immediately. After release, the first accepted pc=7 returns inst_pc=7 with no stale entries.
- With FETCH_STATS_EN: deliver 5 instructions with 2 flushes -> fetch_count=5, flush_count=2. A build without the macro compiles with no stats ports.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and defaults.
// Default widths, queue entry layout and the empty-slot instruction word.
package rv_fetch_pkg;

   localparam int DEF_N     = 32;
   localparam int DEF_W     = 32;
   localparam int DEF_DEPTH = 2;

   // Decode sees this word whenever the queue has nothing to offer.
   localparam logic [DEF_W-1:0] NOP_INST = '0;

   typedef struct packed {
      logic [DEF_W-1:0] inst;
      logic [DEF_N-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {inst, pc} entries.
// clear beats push/pop; pointers wrap modulo DEPTH (power of 2).
module fetch_queue
   import rv_fetch_pkg::*;
#(
   parameter int  DEPTH = DEF_DEPTH,
   parameter type T     = fetch_entry_t,
   parameter int  AW    = $clog2(DEPTH),
   parameter int  CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  T              din,
   output T              dout,
   output logic [CW-1:0] count
);

   T              mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // entry storage; contents are only observed while count != 0
   always_ff @(posedge clk) begin
      if (push && !clear)
         mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: accepts PCs, reads imem (1-cycle latency), queues to decode.
// Define FETCH_STATS_EN to add fetch_count / flush_count outputs.
module instruction_fetch
   import rv_fetch_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int W     = DEF_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] pc_in,
   input  logic         pc_valid,
   output logic         pc_ready,
   output logic         imem_en,
   output logic [N-1:0] imem_addr,
   input  logic [W-1:0] imem_rdata,
   input  logic         flush,
   output logic [W-1:0] inst_out,
   output logic [N-1:0] inst_pc,
   output logic         inst_valid,
   input  logic         inst_ready
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]  fetch_count,
   output logic [31:0]  flush_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [W-1:0] inst;
      logic [N-1:0] pc;
   } entry_t;

   logic          inflight;
   logic [N-1:0]  inflight_pc;
   logic [N-1:0]  addr_q;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          accept;
   logic          push;
   logic          pop;
   entry_t        q_din;
   entry_t        q_dout;

   // queued entries plus the read still in flight must fit the queue
   assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign pc_ready = !rst && !flush && (occ < (CW+1)'(DEPTH));
   assign accept   = pc_valid && pc_ready;

   assign imem_en   = accept;
   assign imem_addr = accept ? pc_in : addr_q;

   assign push = inflight && !flush;
   assign pop  = inst_valid && inst_ready && !flush;

   assign q_din = '{inst: imem_rdata, pc: inflight_pc};

   assign inst_valid = (count != '0);
   assign inst_out   = inst_valid ? q_dout.inst : W'(NOP_INST);
   assign inst_pc    = inst_valid ? q_dout.pc : '0;

   // track the single outstanding memory read and hold the last address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight    <= 1'b0;
         inflight_pc <= '0;
         addr_q      <= '0;
      end else if (flush) begin
         inflight <= 1'b0;
      end else if (accept) begin
         inflight    <= 1'b1;
         inflight_pc <= pc_in;
         addr_q      <= pc_in;
      end else begin
         inflight <= 1'b0;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .din   (q_din),
      .dout  (q_dout),
      .count (count)
   );

`ifdef FETCH_STATS_EN
   // count decode handshakes and flush cycles; both wrap at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= '0;
         flush_count <= '0;
      end else begin
         if (pop)
            fetch_count <= fetch_count + 32'd1;
         if (flush)
            flush_count <= flush_count + 32'd1;
      end
   end
`else
   // no statistics counters in this build
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// Table vectors, directed corner cases and a queue-based reference model.
module tb_instruction_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        flush;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] flush_count;
`endif

   instruction_fetch #(.N(32), .W(32), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .imem_en    (imem_en),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .flush      (flush),
      .inst_out   (inst_out),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready)
`ifdef FETCH_STATS_EN
      ,
      .fetch_count (fetch_count),
      .flush_count (flush_count)
`endif
   );

   always #5 clk = ~clk;

   // synchronous instruction memory: word at addr is A000_0000 + addr
   always @(posedge clk)
      if (imem_en)
         imem_rdata <= 32'hA000_0000 + imem_addr;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   bit          m_inf;
   logic [31:0] m_inf_pc;
   logic [31:0] m_last;
   logic [31:0] m_fetch;
   logic [31:0] m_flush;
   bit          last_acc;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_inf    = 1'b0;
      m_inf_pc = '0;
      m_last   = '0;
      m_fetch  = '0;
      m_flush  = '0;
      last_acc = 1'b0;
   endfunction

   function automatic bit exp_ready();
      return !rst && !flush && ((mq.size() + int'(m_inf)) < DEPTH);
   endfunction

   function automatic void check_outputs();
      bit ev;
      bit er;
      bit ee;
      ev = (mq.size() != 0);
      er = exp_ready();
      ee = pc_valid && er;
      chk("pc_ready", 32'(pc_ready), 32'(er));
      chk("imem_en", 32'(imem_en), 32'(ee));
      chk("imem_addr", imem_addr, ee ? pc_in : m_last);
      chk("inst_valid", 32'(inst_valid), 32'(ev));
      chk("inst_pc", inst_pc, ev ? mq[0].pc : 32'h0);
      chk("inst_out", inst_out, ev ? mq[0].inst : 32'h0);
`ifdef FETCH_STATS_EN
      chk("fetch_count", fetch_count, m_fetch);
      chk("flush_count", flush_count, m_flush);
`endif
   endfunction

   function automatic void model_step();
      bit acc;
      if (rst) begin
         model_reset();
         return;
      end
      acc = pc_valid && exp_ready();
      last_acc = acc;
      if (acc)
         m_last = pc_in;
      if (flush) begin
         mq.delete();
         m_inf = 1'b0;
         m_flush++;
      end else begin
         if (mq.size() != 0 && inst_ready) begin
            void'(mq.pop_front());
            m_fetch++;
         end
         if (m_inf)
            mq.push_back('{inst: 32'hA000_0000 + m_inf_pc, pc: m_inf_pc});
         m_inf = acc;
         if (acc)
            m_inf_pc = pc_in;
      end
   endfunction

   task automatic drive(bit v, logic [31:0] pc, bit fl, bit rdy);
      pc_valid   = v;
      pc_in      = pc;
      flush      = fl;
      inst_ready = rdy;
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic step(bit v, logic [31:0] pc, bit fl, bit rdy);
      drive(v, pc, fl, rdy);
      #1;
      check_outputs();
      advance();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      drive(1'b1, 32'h55, 1'b0, 1'b1);
      #1;
      chk("rst_pc_ready", 32'(pc_ready), 32'h0);
      chk("rst_inst_valid", 32'(inst_valid), 32'h0);
      chk("rst_inst_out", inst_out, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_imem_en", 32'(imem_en), 32'h0);
      advance();
      advance();
      rst = 1'b0;
   endtask

   typedef struct {
      bit          v;
      logic [31:0] pc;
      bit          rdy;
      bit          e_ready;
      bit          e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tbl [18];

   initial begin
      logic [31:0] rpc;
      bit          rv;
      bit          fl;
      bit          rdy;
      int          nacc;
      int          cyc;

      // steady issue with decode always ready, then a decode stall
      tbl[0]  = '{1, 0, 1, 1, 0, 0};
      tbl[1]  = '{1, 1, 1, 1, 0, 0};
      tbl[2]  = '{1, 2, 1, 0, 1, 0};
      tbl[3]  = '{1, 2, 1, 1, 1, 1};
      tbl[4]  = '{1, 3, 1, 1, 0, 0};
      tbl[5]  = '{0, 0, 1, 0, 1, 2};
      tbl[6]  = '{0, 0, 1, 1, 1, 3};
      tbl[7]  = '{0, 0, 1, 1, 0, 0};
      tbl[8]  = '{1, 0, 0, 1, 0, 0};
      tbl[9]  = '{1, 1, 0, 1, 0, 0};
      tbl[10] = '{1, 2, 0, 0, 1, 0};
      tbl[11] = '{1, 2, 0, 0, 1, 0};
      tbl[12] = '{1, 2, 1, 0, 1, 0};
      tbl[13] = '{1, 2, 1, 1, 1, 1};
      tbl[14] = '{1, 3, 1, 1, 0, 0};
      tbl[15] = '{0, 0, 1, 0, 1, 2};
      tbl[16] = '{0, 0, 1, 1, 1, 3};
      tbl[17] = '{0, 0, 1, 1, 0, 0};

      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      model_reset();
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].v, tbl[i].pc, 1'b0, tbl[i].rdy);
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(pc_ready), 32'(tbl[i].e_ready));
         chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
         chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_inst", i), inst_out,
             tbl[i].e_valid ? 32'hA000_0000 + tbl[i].e_pc : 32'h0);
         check_outputs();
         advance();
      end

      // flush while pc=5 returns and pc=4 is queued
      step(1'b1, 32'd4, 1'b0, 1'b0);
      step(1'b1, 32'd5, 1'b0, 1'b0);
      drive(1'b1, 32'd20, 1'b1, 1'b1);
      #1;
      chk("fl_pc_ready", 32'(pc_ready), 32'h0);
      chk("fl_imem_en", 32'(imem_en), 32'h0);
      chk("fl_head_pc", inst_pc, 32'd4);
      check_outputs();
      advance();
      drive(1'b1, 32'd20, 1'b0, 1'b1);
      #1;
      chk("fl_after_valid", 32'(inst_valid), 32'h0);
      chk("fl_redirect_ready", 32'(pc_ready), 32'h1);
      check_outputs();
      advance();
      step(1'b0, 32'd0, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      #1;
      chk("fl_redirect_valid", 32'(inst_valid), 32'h1);
      chk("fl_redirect_pc", inst_pc, 32'd20);
      chk("fl_redirect_inst", inst_out, 32'hA000_0014);
      check_outputs();
      advance();

      // flush coinciding with pc_valid and inst_ready on a busy queue
      step(1'b1, 32'd8, 1'b0, 1'b0);
      step(1'b1, 32'd9, 1'b0, 1'b0);
      drive(1'b1, 32'd10, 1'b1, 1'b1);
      #1;
      chk("flc_pc_ready", 32'(pc_ready), 32'h0);
      chk("flc_imem_en", 32'(imem_en), 32'h0);
      check_outputs();
      advance();
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      #1;
      chk("flc_after_valid", 32'(inst_valid), 32'h0);
      check_outputs();
      advance();

      // randomized traffic, PC held until accepted
      rv  = 1'b0;
      rpc = '0;
      for (int i = 0; i < 400; i++) begin
         if (!rv || last_acc) begin
            rv  = ($urandom_range(3) != 0);
            rpc = $urandom();
         end
         fl  = ($urandom_range(7) == 0);
         rdy = ($urandom_range(3) != 0);
         step(rv, rpc, fl, rdy);
      end

      // async reset between edges with work queued and in flight
      step(1'b1, 32'd30, 1'b0, 1'b0);
      step(1'b1, 32'd31, 1'b0, 1'b0);
      drive(1'b1, 32'd32, 1'b0, 1'b0);
      #1;
      chk("pre_arst_valid", 32'(inst_valid), 32'h1);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_valid", 32'(inst_valid), 32'h0);
      chk("arst_ready", 32'(pc_ready), 32'h0);
      chk("arst_pc", inst_pc, 32'h0);
      check_outputs();
      advance();
      rst = 1'b0;
      step(1'b1, 32'd7, 1'b0, 1'b1);
      step(1'b0, 32'd0, 1'b0, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      #1;
      chk("arst_first_valid", 32'(inst_valid), 32'h1);
      chk("arst_first_pc", inst_pc, 32'd7);
      check_outputs();
      advance();
      drive(1'b0, 32'd0, 1'b0, 1'b1);
      #1;
      chk("arst_no_stale", 32'(inst_valid), 32'h0);
      check_outputs();
      advance();

`ifdef FETCH_STATS_EN
      // five deliveries and two flushes from a clean reset
      do_reset();
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      nacc = 0;
      cyc  = 0;
      while ((nacc < 5 || mq.size() != 0 || m_inf) && cyc < 40) begin
         step(nacc < 5, 32'd100 + 32'(nacc), 1'b0, 1'b1);
         if (last_acc)
            nacc++;
         cyc++;
      end
      chk("stats_timeout", 32'(cyc < 40), 32'h1);
      #1;
      chk("stats_fetch", fetch_count, 32'd5);
      chk("stats_flush", flush_count, 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
